// File: rtl/usb4_os_pkg.sv
// Shared definitions for the ordered-set qualifier: receiver code values,
// qualifier FSM state encoding and small code-classification helpers.
package usb4_os_pkg;

    localparam logic [3:0] OS_SLOS1  = 4'd0;
    localparam logic [3:0] OS_SLOS2  = 4'd1;
    localparam logic [3:0] OS_G3_TS1 = 4'd2;
    localparam logic [3:0] OS_G3_TS2 = 4'd3;
    localparam logic [3:0] OS_G4_TS1 = 4'd4;
    localparam logic [3:0] OS_G4_TS2 = 4'd5;
    localparam logic [3:0] OS_G4_TS3 = 4'd6;
    localparam logic [3:0] OS_G4_TS4 = 4'd7;
    localparam logic [3:0] OS_TL     = 4'd8;
    localparam logic [3:0] OS_NONE   = 4'd9;

    typedef enum logic [1:0] {
        IDLE,
        HUNT,
        COUNT
    } os_state_e;

    function automatic logic os_is_slos(input logic [3:0] code);
        return (code == OS_SLOS1) || (code == OS_SLOS2);
    endfunction

    // Only codes 0..7 are ordered sets that can be qualified.
    function automatic logic os_is_qualifiable(input logic [3:0] code);
        return code <= OS_G4_TS4;
    endfunction

endpackage

// File: rtl/os_qualifier_if.sv
// Bus between the lane-0 receiver side and the logical-layer control FSM.
//   os_in     : ordered-set code from the receiver
//   arm       : qualification enable (level)
//   os_valid  : one-cycle pulse when an ordered set qualifies
//   os_type   : code of the last qualified ordered set (held)
//   tl_active : registered "transport data" indication
//   timeout   : one-cycle pulse when no event arrived in time
interface os_qualifier_if;
    logic [3:0] os_in;
    logic       arm;
    logic       os_valid;
    logic [3:0] os_type;
    logic       tl_active;
    logic       timeout;

    // Driver side (receiver / control FSM)
    modport master (
        output os_in,
        output arm,
        input  os_valid,
        input  os_type,
        input  tl_active,
        input  timeout
    );

    // Qualifier side
    modport slave (
        input  os_in,
        input  arm,
        output os_valid,
        output os_type,
        output tl_active,
        output timeout
    );
endinterface

// File: rtl/os_timeout_timer.sv
// No-event timer for the ordered-set qualifier.
//   i_clk     : clock
//   i_rst     : synchronous active-high reset
//   i_clear   : zero the count (has priority, suppresses expiry)
//   i_enable  : count this cycle
//   o_expire  : high in the cycle the count sits at TIMEOUT_CYCLES-1 while
//               enabled and not cleared; the count restarts from zero
module os_timeout_timer #(
    parameter int CNT_W          = 16,
    parameter int TIMEOUT_CYCLES = 4096
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_clear,
    input  logic i_enable,
    output logic o_expire
);

    localparam logic [CNT_W-1:0] TERM = CNT_W'(TIMEOUT_CYCLES - 1);

    logic [CNT_W-1:0] r_count;

    assign o_expire = i_enable && !i_clear && (r_count == TERM);

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_count <= '0;
        end else if (i_clear || o_expire) begin
            r_count <= '0;
        end else if (i_enable) begin
            r_count <= r_count + 1'b1;
        end
    end

endmodule

// File: rtl/os_qualifier.sv
// Ordered-set qualifier: turns raw receiver codes into entry events, counts
// consecutive identical events and pulses os_valid once a set has repeated
// often enough. Also reports transport-data mode and a no-event timeout.
//   fsm_clk : sole clock
//   rst     : synchronous active-high reset
//   bus     : os_qualifier_if slave (os_in/arm in; os_valid/os_type/
//             tl_active/timeout out)
//
// state | meaning
// ------+--------------------------------------------------
// IDLE  | arm low; events ignored, candidate and timer cleared
// HUNT  | armed, waiting for the first event of a new candidate
// COUNT | armed, candidate held in r_cand with r_rcnt repeats
module os_qualifier
    import usb4_os_pkg::*;
#(
    parameter int TS_REPEAT      = 2,
    parameter int SLOS_REPEAT    = 1,
    parameter int CNT_W          = 16,
    parameter int TIMEOUT_CYCLES = 4096
) (
    input  logic          fsm_clk,
    input  logic          rst,
    os_qualifier_if.slave bus
);

    os_state_e  r_state;
    os_state_e  w_state_nxt;
    logic [3:0] r_prev_os;
    logic [3:0] r_cand;
    logic [3:0] w_cand_nxt;
    logic [3:0] r_rcnt;
    logic [3:0] w_rcnt_nxt;
    logic [3:0] w_rcnt_upd;
    logic [3:0] w_req;
    logic       r_os_valid;
    logic       w_os_valid_nxt;
    logic [3:0] r_os_type;
    logic [3:0] w_os_type_nxt;
    logic       r_tl_active;
    logic       r_timeout;
    logic       w_timeout_nxt;
    logic       w_event;
    logic       w_armed;
    logic       w_expire;

    // An event is the entry into a qualifiable code; holding it is one event.
    assign w_event = os_is_qualifiable(bus.os_in) && (bus.os_in != r_prev_os);

    // Armed means in HUNT/COUNT and staying there; the arming cycle itself
    // is still IDLE, so an event coinciding with arm rising is ignored.
    assign w_armed = bus.arm && (r_state != IDLE);

    assign w_req = os_is_slos(bus.os_in) ? 4'(SLOS_REPEAT) : 4'(TS_REPEAT);

    assign w_rcnt_upd = ((r_state == COUNT) && (bus.os_in == r_cand)) ?
                        r_rcnt + 4'd1 : 4'd1;

    // Event clears the timer, so an event on the expiry cycle wins.
    os_timeout_timer #(
        .CNT_W          (CNT_W),
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) u_timer (
        .i_clk    (fsm_clk),
        .i_rst    (rst),
        .i_clear  (!w_armed || w_event),
        .i_enable (w_armed),
        .o_expire (w_expire)
    );

    always_comb begin
        w_state_nxt    = r_state;
        w_cand_nxt     = r_cand;
        w_rcnt_nxt     = r_rcnt;
        w_os_valid_nxt = 1'b0;
        w_os_type_nxt  = r_os_type;
        w_timeout_nxt  = 1'b0;

        if (!bus.arm) begin
            w_state_nxt = IDLE;
            w_cand_nxt  = 4'd0;
            w_rcnt_nxt  = 4'd0;
        end else begin
            case (r_state)
                IDLE: begin
                    w_state_nxt = HUNT;
                end
                HUNT, COUNT: begin
                    if (w_event) begin
                        if (w_rcnt_upd == w_req) begin
                            w_os_valid_nxt = 1'b1;
                            w_os_type_nxt  = bus.os_in;
                            w_cand_nxt     = 4'd0;
                            w_rcnt_nxt     = 4'd0;
                            w_state_nxt    = HUNT;
                        end else begin
                            w_cand_nxt  = bus.os_in;
                            w_rcnt_nxt  = w_rcnt_upd;
                            w_state_nxt = COUNT;
                        end
                    end else if (w_expire) begin
                        w_timeout_nxt = 1'b1;
                        w_cand_nxt    = 4'd0;
                        w_rcnt_nxt    = 4'd0;
                        w_state_nxt   = HUNT;
                    end
                end
                default: begin
                    w_state_nxt = IDLE;
                    w_cand_nxt  = 4'd0;
                    w_rcnt_nxt  = 4'd0;
                end
            endcase
        end
    end

    always_ff @(posedge fsm_clk) begin
        if (rst) begin
            r_state     <= IDLE;
            r_prev_os   <= OS_NONE;
            r_cand      <= 4'd0;
            r_rcnt      <= 4'd0;
            r_os_valid  <= 1'b0;
            r_os_type   <= OS_NONE;
            r_tl_active <= 1'b0;
            r_timeout   <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_prev_os   <= bus.os_in;
            r_cand      <= w_cand_nxt;
            r_rcnt      <= w_rcnt_nxt;
            r_os_valid  <= w_os_valid_nxt;
            r_os_type   <= w_os_type_nxt;
            r_tl_active <= (bus.os_in == OS_TL);
            r_timeout   <= w_timeout_nxt;
        end
    end

    assign bus.os_valid  = r_os_valid;
    assign bus.os_type   = r_os_type;
    assign bus.tl_active = r_tl_active;
    assign bus.timeout   = r_timeout;

endmodule

// File: tb/tb_os_qualifier.sv
// Directed bench for os_qualifier. Two instances share the stimulus: dut with
// default parameters for qualification behaviour, dut_t with a 16-cycle
// timeout for the timer behaviour.
module tb_os_qualifier;

    typedef struct packed {
        logic       v;
        logic [3:0] t;
        logic       to;
        logic       tl;
        logic       chk_t;
        logic       to_t;
    } exp_t;

    logic       fsm_clk = 1'b0;
    logic       rst;
    logic       arm_v;
    logic [3:0] m_type;
    int         n_checks = 0;
    int         n_errors = 0;
    int         step = 0;
    exp_t       sb[$];

    os_qualifier_if qif ();
    os_qualifier_if qif_t ();

    assign qif_t.os_in = qif.os_in;
    assign qif_t.arm   = qif.arm;

    os_qualifier dut (
        .fsm_clk (fsm_clk),
        .rst     (rst),
        .bus     (qif)
    );

    os_qualifier #(.TIMEOUT_CYCLES(16)) dut_t (
        .fsm_clk (fsm_clk),
        .rst     (rst),
        .bus     (qif_t)
    );

    initial forever #5 fsm_clk = ~fsm_clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    task automatic check_out();
        exp_t e;
        if (sb.size() == 0) begin
            n_checks++;
            n_errors++;
            $display("FAIL scoreboard step %0d: got empty queue, want entry", step);
            return;
        end
        e = sb.pop_front();
        n_checks++;
        assert (qif.os_valid === e.v) else begin
            n_errors++;
            $error("FAIL os_valid step %0d: got %b want %b", step, qif.os_valid, e.v);
        end
        n_checks++;
        assert (qif.os_type === e.t) else begin
            n_errors++;
            $error("FAIL os_type step %0d: got %h want %h", step, qif.os_type, e.t);
        end
        n_checks++;
        assert (qif.timeout === e.to) else begin
            n_errors++;
            $error("FAIL timeout step %0d: got %b want %b", step, qif.timeout, e.to);
        end
        n_checks++;
        assert (qif.tl_active === e.tl) else begin
            n_errors++;
            $error("FAIL tl_active step %0d: got %b want %b", step, qif.tl_active, e.tl);
        end
        if (e.chk_t) begin
            n_checks++;
            assert (qif_t.timeout === e.to_t) else begin
                n_errors++;
                $error("FAIL timeout16 step %0d: got %b want %b", step, qif_t.timeout, e.to_t);
            end
            n_checks++;
            assert (qif_t.os_valid === 1'b0) else begin
                n_errors++;
                $error("FAIL os_valid16 step %0d: got %b want 0", step, qif_t.os_valid);
            end
        end
    endtask

    // Drive one cycle of stimulus, queue what the outputs must be after the
    // next edge, then sample 1 ns after that edge.
    task automatic cyc(input logic [3:0] code, input logic a, input logic r,
                       input logic ev, input logic chk_t, input logic eto_t);
        exp_t e;
        qif.os_in = code;
        qif.arm   = a;
        rst       = r;
        step++;
        if (r)
            m_type = 4'h9;
        else if (ev)
            m_type = code;
        e.v     = ev && !r;
        e.t     = m_type;
        e.to    = 1'b0;
        e.tl    = (code == 4'h8) && !r;
        e.chk_t = chk_t;
        e.to_t  = eto_t;
        sb.push_back(e);
        @(posedge fsm_clk);
        #1;
        check_out();
    endtask

    task automatic run(input logic [3:0] code, input logic ev);
        cyc(code, arm_v, 1'b0, ev, 1'b0, 1'b0);
    endtask

    initial begin
        qif.os_in = 4'h9;
        qif.arm   = 1'b0;
        rst       = 1'b1;
        arm_v     = 1'b0;
        m_type    = 4'h9;

        // Reset values
        cyc(4'h9, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        cyc(4'h9, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);

        // TS repeat: first 2 does not qualify, second does
        arm_v = 1'b1;
        run(4'h9, 1'b0);
        run(4'h2, 1'b0);
        run(4'h9, 1'b0);
        run(4'h2, 1'b1);
        run(4'h9, 1'b0);

        // Held code is one event; leaving and returning qualifies
        for (int i = 0; i < 50; i++) run(4'h4, 1'b0);
        run(4'h9, 1'b0);
        run(4'h4, 1'b1);
        run(4'h9, 1'b0);

        // Type switch restarts the count
        run(4'h2, 1'b0);
        run(4'h9, 1'b0);
        run(4'h3, 1'b0);
        run(4'h9, 1'b0);
        run(4'h3, 1'b1);
        run(4'h9, 1'b0);

        // SLOS qualifies on a single event
        run(4'h1, 1'b1);
        run(4'h9, 1'b0);

        // Disarm clears the candidate; event on the arming cycle is ignored
        run(4'h5, 1'b0);
        run(4'h9, 1'b0);
        arm_v = 1'b0;
        run(4'h9, 1'b0);
        arm_v = 1'b1;
        run(4'h5, 1'b0);
        run(4'h9, 1'b0);
        run(4'h5, 1'b0);
        run(4'h9, 1'b0);
        arm_v = 1'b0;
        run(4'h9, 1'b0);
        arm_v = 1'b1;
        run(4'h9, 1'b0);

        // Illegal code between repeats is ignored
        run(4'h5, 1'b0);
        run(4'h9, 1'b0);
        run(4'hA, 1'b0);
        run(4'h5, 1'b1);
        run(4'h9, 1'b0);

        // Transport data, armed and in IDLE
        run(4'h8, 1'b0);
        run(4'h9, 1'b0);
        arm_v = 1'b0;
        run(4'h8, 1'b0);
        run(4'h9, 1'b0);

        // Reset mid-COUNT discards a qualification that was about to happen
        arm_v = 1'b1;
        run(4'h9, 1'b0);
        run(4'h6, 1'b0);
        run(4'h9, 1'b0);
        cyc(4'h6, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        run(4'h9, 1'b0);
        run(4'h6, 1'b0);
        run(4'h9, 1'b0);
        run(4'h6, 1'b1);
        run(4'h9, 1'b0);

        // Timeout on the 16-cycle instance: pulses at 16, 32; an event on
        // the expiry cycle (48) suppresses it; next pulse at 64
        arm_v = 1'b0;
        run(4'h9, 1'b0);
        run(4'h9, 1'b0);
        arm_v = 1'b1;
        cyc(4'h9, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
        for (int k = 1; k <= 64; k++) begin
            cyc((k == 48) ? 4'h2 : 4'h9, 1'b1, 1'b0, 1'b0, 1'b1,
                (k == 16) || (k == 32) || (k == 64));
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
